// File: rtl/id_operand_stage.sv
// Decode-stage register: operand read, multi-channel forwarding, load-use interlock and an
// operand hold register. Define ID_PERF_CNT_EN to add stall/flush/issue counters.
module id_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned PW      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [PW-1:0]           i_in_payload,
  input  logic [NUM_SRC*5-1:0]    i_in_src_addr,
  input  logic [NUM_SRC-1:0]      i_in_src_use,
  input  logic                    i_flush,
  output logic [NUM_SRC*5-1:0]    o_rf_raddr,
  input  logic [NUM_SRC*XLEN-1:0] i_rf_rdata,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD-1:0]      i_fwd_we,
  input  logic [NUM_FWD*5-1:0]    i_fwd_dest,
  input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
  input  logic [NUM_FWD-1:0]      i_fwd_data_ok,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [PW-1:0]           o_out_payload,
  output logic [NUM_SRC*XLEN-1:0] o_out_src_data,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]             o_perf_stall_cnt,
  output logic [31:0]             o_perf_flush_cnt,
  output logic [31:0]             o_perf_issue_cnt,
`endif
  output logic                    o_stall
);

  logic                    r_vld;
  logic [PW-1:0]           r_payload;
  logic [NUM_SRC*5-1:0]    r_src_addr;
  logic [NUM_SRC-1:0]      r_src_use;
  logic                    r_hold_vld;
  logic [NUM_SRC*XLEN-1:0] r_hold_data;

  logic [NUM_FWD-1:0]      w_match [NUM_SRC];
  logic [NUM_SRC-1:0]      w_hit;
  logic [NUM_SRC-1:0]      w_blocked;
  logic [NUM_SRC*XLEN-1:0] w_resolved;
  logic                    w_stall;
  logic                    w_out_valid;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_fire;

  always_comb begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      for (int unsigned c = 0; c < NUM_FWD; c++) begin
        w_match[s][c] = r_vld & r_src_use[s] & i_fwd_valid[c] & i_fwd_we[c] &
                        (i_fwd_dest[c*5 +: 5] != 5'd0) &
                        (i_fwd_dest[c*5 +: 5] == r_src_addr[s*5 +: 5]);
      end
    end
  end

  // The first matching channel decides; a blocked young producer must not be skipped.
  always_comb begin
    w_hit      = '0;
    w_blocked  = '0;
    w_resolved = i_rf_rdata;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      for (int unsigned c = 0; c < NUM_FWD; c++) begin
        if (!w_hit[s] && w_match[s][c]) begin
          w_hit[s] = 1'b1;
          if (i_fwd_data_ok[c]) begin
            w_resolved[s*XLEN +: XLEN] = i_fwd_data[c*XLEN +: XLEN];
          end else begin
            w_blocked[s] = 1'b1;
          end
        end
      end
      if (r_src_addr[s*5 +: 5] == 5'd0) begin
        w_resolved[s*XLEN +: XLEN] = '0;
      end
    end
  end

  assign w_stall     = r_vld & ~r_hold_vld & (|w_blocked);
  assign w_out_valid = r_vld & ~w_stall;
  assign w_in_ready  = ~r_vld | (~w_stall & i_out_ready);
  assign w_accept    = i_in_valid & w_in_ready;
  assign w_fire      = w_out_valid & i_out_ready;

  assign o_stall        = w_stall;
  assign o_out_valid    = w_out_valid;
  assign o_in_ready     = w_in_ready;
  assign o_out_payload  = r_payload;
  assign o_rf_raddr     = r_src_addr;
  assign o_out_src_data = r_hold_vld ? r_hold_data : w_resolved;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld       <= 1'b0;
      r_payload   <= '0;
      r_src_addr  <= '0;
      r_src_use   <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else begin
      if (i_flush) begin
        r_vld <= 1'b0;
      end else if (w_in_ready) begin
        r_vld <= i_in_valid;
      end

      if (w_accept) begin
        r_payload  <= i_in_payload;
        r_src_addr <= i_in_src_addr;
        r_src_use  <= i_in_src_use;
      end

      // Freeze operands on the first back-pressured cycle so EXU sees stable data.
      if (i_flush || w_fire) begin
        r_hold_vld <= 1'b0;
      end else if (w_out_valid && !i_out_ready && !r_hold_vld) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= w_resolved;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;
  logic [31:0] r_perf_issue_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
      r_perf_issue_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (i_flush && r_vld) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
      if (w_fire) begin
        r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
  assign o_perf_issue_cnt = r_perf_issue_cnt;
`endif

endmodule
